// File: rtl/pid_pkg.sv
// Shared encodings, register map and datapath widths for the multi-channel PID controller.
// Optional feature macro used by the controller: PID_FEEDFORWARD_EN.
package pid_pkg;

    typedef enum logic [1:0] {
        MODE_POS  = 2'b00,
        MODE_VEL  = 2'b01,
        MODE_DISP = 2'b10,
        MODE_OFF  = 2'b11
    } mode_t;

    localparam logic [3:0] ADDR_KP         = 4'd0;
    localparam logic [3:0] ADDR_KI         = 4'd1;
    localparam logic [3:0] ADDR_KD         = 4'd2;
    localparam logic [3:0] ADDR_SP         = 4'd3;
    localparam logic [3:0] ADDR_FWD        = 4'd4;
    localparam logic [3:0] ADDR_OUT_MAX    = 4'd5;
    localparam logic [3:0] ADDR_OUT_MIN    = 4'd6;
    localparam logic [3:0] ADDR_I_MAX      = 4'd7;
    localparam logic [3:0] ADDR_I_MIN      = 4'd8;
    localparam logic [3:0] ADDR_DEADBAND   = 4'd9;
    localparam logic [3:0] ADDR_MODE       = 4'd10;
    localparam logic [3:0] ADDR_CLR_STATUS = 4'd11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MUL,
        S_SUM,
        S_STORE
    } state_t;

    localparam int REG_W     = 16;
    localparam int ERR_W     = 32;
    localparam int PROD_W    = 48;
    localparam int INT_SUM_W = 49;
    localparam int ACC_W     = 50;

    localparam logic signed [ERR_W-1:0] ERR_MAX = 32'sh7fff_ffff;
    localparam logic signed [ERR_W-1:0] ERR_MIN = 32'sh8000_0000;

endpackage

// File: rtl/pid_sat.sv
// Signed saturate/clamp of a wide value into [lo, hi] of a narrower (or equal) width.
module pid_sat #(
    parameter int IN_W  = 33,
    parameter int OUT_W = 32
) (
    input  logic signed [IN_W-1:0]  value,
    input  logic signed [OUT_W-1:0] lo,
    input  logic signed [OUT_W-1:0] hi,
    output logic signed [OUT_W-1:0] sat,
    output logic                    clamped
);

    logic signed [IN_W-1:0] lo_ext;
    logic signed [IN_W-1:0] hi_ext;

    always_comb begin
        lo_ext = IN_W'(lo);
        hi_ext = IN_W'(hi);
        if (value < lo_ext) begin
            sat     = lo;
            clamped = 1'b1;
        end else if (value > hi_ext) begin
            sat     = hi;
            clamped = 1'b1;
        end else begin
            sat     = OUT_W'(value);
            clamped = 1'b0;
        end
    end

endmodule

// File: rtl/pid_controller_mc.sv
// Time-multiplexed NUM_CH-channel PID controller: one LOAD/MUL/SUM/STORE pass per channel per sweep.
// Define PID_FEEDFORWARD_EN to add the per-channel forwardGain register and feed-forward term.
module pid_controller_mc
    import pid_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int GAIN_SHIFT = 0,
    parameter int POS_W      = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      cfg_we,
    input  logic [3:0]                cfg_ch,
    input  logic [3:0]                cfg_addr,
    input  logic [31:0]               cfg_wdata,
    input  logic [NUM_CH*POS_W-1:0]   position,
    input  logic [NUM_CH*16-1:0]      velocity,
    input  logic [NUM_CH*16-1:0]      displacement,
    input  logic                      update_controller,
    output logic [NUM_CH*ERR_W-1:0]   result,
    output logic                      busy,
    output logic                      done,
    output logic                      overrun
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DEPTH = 1 << CH_W;
    localparam int RAW_W = POS_W + 1;

    logic signed [POS_W-1:0] pos_arr  [DEPTH];
    logic signed [15:0]      vel_arr  [DEPTH];
    logic [14:0]             disp_arr [DEPTH];
    logic [DEPTH-1:0]        unused_disp_msb;

    logic signed [REG_W-1:0] kp [DEPTH], ki [DEPTH], kd [DEPTH];
    logic signed [REG_W-1:0] out_max [DEPTH], out_min [DEPTH];
    logic signed [REG_W-1:0] i_max [DEPTH], i_min [DEPTH];
    logic [REG_W-1:0]        dead_band [DEPTH];
    mode_t                   mode [DEPTH];
    logic signed [POS_W-1:0] sp [DEPTH];
`ifdef PID_FEEDFORWARD_EN
    logic signed [REG_W-1:0] fwd_gain [DEPTH];
`endif

    logic signed [ERR_W-1:0] result_q [DEPTH];
    logic signed [ERR_W-1:0] integ [DEPTH];
    logic signed [ERR_W-1:0] last_err [DEPTH];
    logic                    clamped_q [DEPTH];

    state_t          state;
    logic [CH_W-1:0] ch;
    logic            strobe_prev, start;
    logic            cfg_hit, clr_status;
    logic            vld_p0, vld_p1, vld_p2;

    for (genvar c = 0; c < DEPTH; c++) begin : g_chan
        if (c < NUM_CH) begin : g_live
            assign pos_arr[c]         = $signed(position[c*POS_W +: POS_W]);
            assign vel_arr[c]         = $signed(velocity[c*16 +: 16]);
            assign disp_arr[c]        = displacement[c*16 +: 15];
            assign unused_disp_msb[c] = displacement[c*16+15];
            assign result[c*ERR_W +: ERR_W] = result_q[c];
        end else begin : g_pad
            assign pos_arr[c]         = '0;
            assign vel_arr[c]         = '0;
            assign disp_arr[c]        = '0;
            assign unused_disp_msb[c] = 1'b0;
        end
    end

    assign start      = update_controller & ~strobe_prev;
    assign cfg_hit    = cfg_we && (int'(cfg_ch) < NUM_CH);
    assign clr_status = cfg_hit && (cfg_addr == ADDR_CLR_STATUS);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            ch          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overrun     <= 1'b0;
            strobe_prev <= 1'b0;
            vld_p0      <= 1'b0;
            vld_p1      <= 1'b0;
            vld_p2      <= 1'b0;
        end else begin
            strobe_prev <= update_controller;
            done        <= 1'b0;
            vld_p0      <= (state == S_LOAD);
            vld_p1      <= vld_p0;
            vld_p2      <= vld_p1;
            if (start && busy)
                overrun <= 1'b1;
            else if (clr_status)
                overrun <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_LOAD;
                        ch    <= '0;
                        busy  <= 1'b1;
                    end
                end
                S_LOAD:  state <= S_MUL;
                S_MUL:   state <= S_SUM;
                S_SUM:   state <= S_STORE;
                S_STORE: begin
                    if (int'(ch) == NUM_CH - 1) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        ch    <= ch + CH_W'(1);
                        state <= S_LOAD;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ---- stage LOAD: error select, saturation and deadband test ----
    logic signed [RAW_W-1:0] err_raw;
    logic signed [ERR_W-1:0] err_sat;
    logic signed [ERR_W:0]   err_ext;
    logic [ERR_W:0]          err_abs;
    logic                    unused_err_clamp;
    logic                    hold;

    always_comb begin
        err_raw = '0;
        case (mode[ch])
            MODE_POS:  err_raw = RAW_W'(sp[ch]) - RAW_W'(pos_arr[ch]);
            MODE_VEL:  err_raw = RAW_W'(sp[ch]) - RAW_W'(vel_arr[ch]);
            MODE_DISP: if (!disp_arr[ch][14])
                           err_raw = RAW_W'(sp[ch]) - $signed(RAW_W'(disp_arr[ch]));
            default:   err_raw = '0;
        endcase
    end

    pid_sat #(.IN_W(RAW_W), .OUT_W(ERR_W)) u_err_sat (
        .value(err_raw), .lo(ERR_MIN), .hi(ERR_MAX), .sat(err_sat), .clamped(unused_err_clamp)
    );

    always_comb begin
        err_ext = (ERR_W+1)'(err_sat);
        err_abs = (err_ext < 0) ? -err_ext : err_ext;
        hold    = (mode[ch] == MODE_OFF) || (err_abs < (ERR_W+1)'(dead_band[ch]));
    end

    logic signed [ERR_W-1:0] err_p0, last_err_p0, integ_p0;
    logic signed [REG_W-1:0] kp_p0, ki_p0, kd_p0, out_max_p0, out_min_p0, i_max_p0, i_min_p0;
    logic                    hold_p0, clamped_prev_p0;
`ifdef PID_FEEDFORWARD_EN
    logic signed [REG_W-1:0] fwd_p0;
    logic signed [POS_W-1:0] sp_p0;
`endif

    always_ff @(posedge clock) begin
        if (state == S_LOAD) begin
            err_p0          <= err_sat;
            last_err_p0     <= last_err[ch];
            integ_p0        <= integ[ch];
            kp_p0           <= kp[ch];
            ki_p0           <= ki[ch];
            kd_p0           <= kd[ch];
            out_max_p0      <= out_max[ch];
            out_min_p0      <= out_min[ch];
            i_max_p0        <= i_max[ch];
            i_min_p0        <= i_min[ch];
            hold_p0         <= hold;
            clamped_prev_p0 <= clamped_q[ch];
`ifdef PID_FEEDFORWARD_EN
            fwd_p0          <= fwd_gain[ch];
            sp_p0           <= sp[ch];
`endif
        end
    end

    // ---- stage MUL: gain products ----
    logic signed [ERR_W:0]    diff_raw;
    logic signed [ERR_W-1:0]  diff_sat;
    logic                     unused_diff_clamp;
    logic signed [PROD_W-1:0] p_prod, i_prod, d_prod;

    assign diff_raw = (ERR_W+1)'(err_p0) - (ERR_W+1)'(last_err_p0);

    pid_sat #(.IN_W(ERR_W+1), .OUT_W(ERR_W)) u_diff_sat (
        .value(diff_raw), .lo(ERR_MIN), .hi(ERR_MAX), .sat(diff_sat), .clamped(unused_diff_clamp)
    );

    assign p_prod = PROD_W'(kp_p0) * PROD_W'(err_p0);
    assign i_prod = PROD_W'(ki_p0) * PROD_W'(err_p0);
    assign d_prod = PROD_W'(kd_p0) * PROD_W'(diff_sat);

    logic signed [PROD_W-1:0] pterm_p1, iterm_p1, dterm_p1;
    logic signed [ERR_W-1:0]  err_p1, integ_p1;
    logic signed [REG_W-1:0]  out_max_p1, out_min_p1, i_max_p1, i_min_p1;
    logic                     hold_p1, clamped_prev_p1;
`ifdef PID_FEEDFORWARD_EN
    logic signed [PROD_W-1:0] ffterm_p1;
`endif

    always_ff @(posedge clock) begin
        if (vld_p0) begin
            pterm_p1        <= p_prod >>> GAIN_SHIFT;
            iterm_p1        <= i_prod >>> GAIN_SHIFT;
            dterm_p1        <= d_prod >>> GAIN_SHIFT;
            err_p1          <= err_p0;
            integ_p1        <= integ_p0;
            out_max_p1      <= out_max_p0;
            out_min_p1      <= out_min_p0;
            i_max_p1        <= i_max_p0;
            i_min_p1        <= i_min_p0;
            hold_p1         <= hold_p0;
            clamped_prev_p1 <= clamped_prev_p0;
`ifdef PID_FEEDFORWARD_EN
            ffterm_p1       <= (PROD_W'(fwd_p0) * PROD_W'(sp_p0)) >>> GAIN_SHIFT;
`endif
        end
    end

    // ---- stage SUM: integral with anti-windup, output sum and clamp ----
    logic signed [PROD_W-1:0]    ff_add;
    logic signed [INT_SUM_W-1:0] int_add;
    logic signed [ERR_W-1:0]     int_new, sum_sat, out_val;
    logic signed [ACC_W-1:0]     sum_raw;
    logic                        unused_int_clamp, sum_flag, out_flag;

`ifdef PID_FEEDFORWARD_EN
    assign ff_add = ffterm_p1;
`else
    assign ff_add = '0;
`endif

    assign int_add = (hold_p1 || clamped_prev_p1) ? INT_SUM_W'(integ_p1)
                                                  : INT_SUM_W'(integ_p1) + INT_SUM_W'(iterm_p1);

    pid_sat #(.IN_W(INT_SUM_W), .OUT_W(ERR_W)) u_int_sat (
        .value(int_add), .lo(ERR_W'(i_min_p1)), .hi(ERR_W'(i_max_p1)),
        .sat(int_new), .clamped(unused_int_clamp)
    );

    assign sum_raw = hold_p1 ? ACC_W'(int_new)
                             : ACC_W'(pterm_p1) + ACC_W'(int_new) + ACC_W'(dterm_p1) + ACC_W'(ff_add);

    pid_sat #(.IN_W(ACC_W), .OUT_W(ERR_W)) u_sum_sat (
        .value(sum_raw), .lo(ERR_MIN), .hi(ERR_MAX), .sat(sum_sat), .clamped(sum_flag)
    );

    pid_sat #(.IN_W(ERR_W), .OUT_W(ERR_W)) u_out_clamp (
        .value(sum_sat), .lo(ERR_W'(out_min_p1)), .hi(ERR_W'(out_max_p1)),
        .sat(out_val), .clamped(out_flag)
    );

    logic signed [ERR_W-1:0] result_p2, integ_p2, err_p2;
    logic                    clamped_p2;

    always_ff @(posedge clock) begin
        if (vld_p1) begin
            result_p2  <= out_val;
            integ_p2   <= int_new;
            err_p2     <= err_p1;
            clamped_p2 <= sum_flag | out_flag;
        end
    end

    // ---- stage STORE: per-channel state and configuration registers ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < DEPTH; c++) begin
                kp[c]        <= '0;
                ki[c]        <= '0;
                kd[c]        <= '0;
                sp[c]        <= '0;
                out_max[c]   <= 16'sh7fff;
                out_min[c]   <= 16'sh8000;
                i_max[c]     <= '0;
                i_min[c]     <= '0;
                dead_band[c] <= '0;
                mode[c]      <= MODE_POS;
`ifdef PID_FEEDFORWARD_EN
                fwd_gain[c]  <= '0;
`endif
                result_q[c]  <= '0;
                integ[c]     <= '0;
                last_err[c]  <= '0;
                clamped_q[c] <= 1'b0;
            end
        end else begin
            if (cfg_hit) begin
                case (cfg_addr)
                    ADDR_KP:       kp[cfg_ch[CH_W-1:0]]        <= $signed(cfg_wdata[15:0]);
                    ADDR_KI:       ki[cfg_ch[CH_W-1:0]]        <= $signed(cfg_wdata[15:0]);
                    ADDR_KD:       kd[cfg_ch[CH_W-1:0]]        <= $signed(cfg_wdata[15:0]);
                    ADDR_SP:       sp[cfg_ch[CH_W-1:0]]        <= POS_W'($signed(cfg_wdata));
`ifdef PID_FEEDFORWARD_EN
                    ADDR_FWD:      fwd_gain[cfg_ch[CH_W-1:0]]  <= $signed(cfg_wdata[15:0]);
`endif
                    ADDR_OUT_MAX:  out_max[cfg_ch[CH_W-1:0]]   <= $signed(cfg_wdata[15:0]);
                    ADDR_OUT_MIN:  out_min[cfg_ch[CH_W-1:0]]   <= $signed(cfg_wdata[15:0]);
                    ADDR_I_MAX:    i_max[cfg_ch[CH_W-1:0]]     <= $signed(cfg_wdata[15:0]);
                    ADDR_I_MIN:    i_min[cfg_ch[CH_W-1:0]]     <= $signed(cfg_wdata[15:0]);
                    ADDR_DEADBAND: dead_band[cfg_ch[CH_W-1:0]] <= cfg_wdata[15:0];
                    ADDR_MODE:     mode[cfg_ch[CH_W-1:0]]      <= mode_t'(cfg_wdata[1:0]);
                    default: ;
                endcase
            end
            if (vld_p2) begin
                result_q[ch]  <= result_p2;
                integ[ch]     <= integ_p2;
                last_err[ch]  <= err_p2;
                clamped_q[ch] <= clamped_p2;
            end
        end
    end

endmodule

// File: tb/tb_pid_controller_mc.sv
// Directed bench for pid_controller_mc (NUM_CH=4, GAIN_SHIFT=0) with hand-computed expectations.
module tb_pid_controller_mc;
    import pid_pkg::*;

    logic         clock = 1'b0;
    logic         reset;
    logic         cfg_we;
    logic [3:0]   cfg_ch;
    logic [3:0]   cfg_addr;
    logic [31:0]  cfg_wdata;
    logic [127:0] position;
    logic [63:0]  velocity;
    logic [63:0]  displacement;
    logic         update_controller;
    logic [127:0] result;
    logic         busy, done, overrun;

    int checks   = 0;
    int failures = 0;
    int n;
    int dcount;

    pid_controller_mc #(.NUM_CH(4), .GAIN_SHIFT(0), .POS_W(32)) dut (
        .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .position(position), .velocity(velocity),
        .displacement(displacement), .update_controller(update_controller),
        .result(result), .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clock = ~clock;

    function automatic logic signed [31:0] res(input int c);
        return result[c*32 +: 32];
    endfunction

    task automatic check(input string tag, input longint obs, input longint exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic cfg_write(input int c, input logic [3:0] a, input logic [31:0] d);
        @(negedge clock);
        cfg_we = 1'b1; cfg_ch = 4'(c); cfg_addr = a; cfg_wdata = d;
        @(negedge clock);
        cfg_we = 1'b0;
    endtask

    // Raise the strobe, then count posedges until done (0 means no done within the budget).
    task automatic sweep(input string tag);
        int cyc;
        cyc = 0;
        @(negedge clock);
        update_controller = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clock);
            #1;
            update_controller = 1'b0;
            if (done) begin
                cyc = i;
                break;
            end
        end
        check({tag, "_done_cycle"}, cyc, 17);
    endtask

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_addr = '0; cfg_wdata = '0;
        position = '0; velocity = '0; displacement = '0; update_controller = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        for (int c = 0; c < 4; c++) check($sformatf("rst_result%0d", c), res(c), 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overrun", overrun, 0);
        @(negedge clock);
        reset = 1'b0;

        // Proportional only, ch0: err = 100 - 40 = 60, Kp=2
        cfg_write(0, ADDR_KP, 32'd2);
        cfg_write(0, ADDR_SP, 32'd100);
        cfg_write(0, ADDR_OUT_MAX, 32'd1000);
        cfg_write(0, ADDR_OUT_MIN, 32'hFFFF_FC18);
        position[31:0] = 32'd40;
        sweep("p_only");
        check("p_only_ch0", res(0), 120);
        check("p_only_ch1", res(1), 0);
        check("p_only_busy", busy, 0);

        // Output clamp and anti-windup
        cfg_write(0, ADDR_KP, 32'd100);
        sweep("clamp");
        check("clamp_ch0", res(0), 1000);
        cfg_write(0, ADDR_I_MAX, 32'd1000);
        cfg_write(0, ADDR_I_MIN, 32'hFFFF_FC18);
        cfg_write(0, ADDR_KI, 32'd1);
        sweep("windup1");
        check("windup1_ch0", res(0), 1000);
        sweep("windup2");
        check("windup2_ch0", res(0), 1000);
        cfg_write(0, ADDR_KP, 32'd0);
        sweep("windup3");
        check("windup_held_integral", res(0), 0);
        cfg_write(0, ADDR_FWD, 32'd5);
        sweep("windup4");
`ifdef PID_FEEDFORWARD_EN
        check("integral_resumes", res(0), 560);
`else
        check("integral_resumes", res(0), 60);
`endif

        // Integral clamp, ch1: err=10, Ki=1, limits +-25
        cfg_write(1, ADDR_KI, 32'd1);
        cfg_write(1, ADDR_I_MAX, 32'd25);
        cfg_write(1, ADDR_I_MIN, 32'hFFFF_FFE7);
        cfg_write(1, ADDR_SP, 32'd10);
        sweep("int1"); check("int1_ch1", res(1), 10);
        sweep("int2"); check("int2_ch1", res(1), 20);
        sweep("int3"); check("int3_ch1", res(1), 25);
        sweep("int4"); check("int4_ch1", res(1), 25);

        // Derivative, ch2: err 0 -> 10 -> 10 with Kd=3
        cfg_write(2, ADDR_KD, 32'd3);
        sweep("d0"); check("d0_ch2", res(2), 0);
        position[95:64] = -32'sd10;
        sweep("d1"); check("d_step_ch2", res(2), 30);
        sweep("d2"); check("d_const_ch2", res(2), 0);

        // Deadband and input modes, ch3
        cfg_write(3, ADDR_KP, 32'd2);
        cfg_write(3, ADDR_KI, 32'd1);
        cfg_write(3, ADDR_I_MAX, 32'd100);
        cfg_write(3, ADDR_I_MIN, 32'hFFFF_FF9C);
        cfg_write(3, ADDR_SP, 32'd50);
        sweep("db0"); check("db_prime_ch3", res(3), 150);
        cfg_write(3, ADDR_DEADBAND, 32'd10);
        cfg_write(3, ADDR_SP, 32'd5);
        sweep("db1"); check("deadband_hold_ch3", res(3), 50);
        cfg_write(3, ADDR_DEADBAND, 32'd0);
        cfg_write(3, ADDR_MODE, {30'd0, MODE_DISP});
        displacement[63:48] = 16'h4010;
        sweep("disp0"); check("disp_bit14_zero_err", res(3), 50);
        displacement[63:48] = 16'h0010;
        sweep("disp1"); check("disp_err_neg11", res(3), 17);
        cfg_write(3, ADDR_MODE, {30'd0, MODE_OFF});
        sweep("off"); check("mode_off_held", res(3), 39);
        cfg_write(3, ADDR_MODE, {30'd0, MODE_VEL});
        velocity[63:48] = 16'hFFEC;
        sweep("vel"); check("vel_sext_ch3", res(3), 114);

        // Overrun: second edge while busy is dropped
        @(negedge clock);
        update_controller = 1'b1;
        @(posedge clock); #1;
        update_controller = 1'b0;
        check("ovr_busy", busy, 1);
        repeat (2) @(negedge clock);
        update_controller = 1'b1;
        @(posedge clock); #1;
        update_controller = 1'b0;
        check("overrun_set", overrun, 1);
        dcount = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clock); #1;
            if (done) dcount++;
        end
        check("single_sweep", dcount, 1);
        check("idle_after_ovr", busy, 0);
        check("overrun_sticky", overrun, 1);
        cfg_write(0, ADDR_CLR_STATUS, 32'd0);
        check("overrun_cleared", overrun, 0);

        // Reset in the middle of a sweep
        @(negedge clock);
        update_controller = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        update_controller = 1'b0;
        check("mid_busy", busy, 1);
        check("mid_ch0_nonzero", (res(0) != 0), 1);
        reset = 1'b1;
        #1;
        for (int c = 0; c < 4; c++) check($sformatf("abort_result%0d", c), res(c), 0);
        @(posedge clock); #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        @(negedge clock);
        reset = 1'b0;
        sweep("post_rst");
        check("post_rst_ch0", res(0), 0);
        check("post_rst_ch3", res(3), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
